// File: rtl/cache_mem_pkg.sv
// Shared types and limits for the line-granular memory responder.
package cache_mem_pkg;

    localparam int LINE_W      = 128;
    localparam int LINE_ADDR_W = 12;
    localparam int MAX_LATENCY = 255;
    localparam int CNT_W       = 8;

    typedef logic [LINE_W-1:0]      line_t;
    typedef logic [LINE_ADDR_W-1:0] line_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } resp_state_t;

endpackage

// File: rtl/line_store.sv
// Backing store: one line per address, synchronous write, registered read, no reset.
module line_store #(
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [LINE_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [LINE_WIDTH-1:0] rdata
);

    logic [LINE_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // The read register only loads on re, so the last read line stays put.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cache_line_responder.sv
// Memory-side responder: one line request at a time, completion after a fixed
// latency, sticky protocol-error flag and wrapping completion counters.
module cache_line_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WIDTH = 128,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic                  mem_resp,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  proto_err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("cache_line_responder: LATENCY must be in 1..255");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic             DIRECT_RESP = (LATENCY == 1);

    resp_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic                  op_write;
    logic                  rdata_vld;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] store_rdata;

    logic                  req_one;
    logic                  accept;
    logic                  req_held;
    logic                  enter_resp;
    logic                  next_write;
    logic                  store_re;
    logic                  store_we;
    logic [ADDR_WIDTH-1:0] store_raddr;

    always_comb begin
        req_one     = mem_read ^ mem_write;
        accept      = (state == IDLE) && req_one;
        req_held    = op_write ? mem_write : mem_read;
        // The counter reaches zero on the same edge that enters RESP.
        enter_resp  = (accept && DIRECT_RESP) ||
                      ((state == BUSY) && req_held && (cnt == CNT_W'(1)));
        next_write  = (state == IDLE) ? mem_write : op_write;
        store_re    = enter_resp && !next_write;
        store_raddr = (state == IDLE) ? mem_address : addr_q;
        store_we    = (state == RESP) && op_write;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= mem_address;
            wdata_q <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            mem_resp  <= 1'b0;
            rdata_vld <= 1'b0;
            proto_err <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            mem_resp <= enter_resp;
            if (store_re) begin
                rdata_vld <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_read && mem_write) begin
                        proto_err <= 1'b1;
                    end else if (accept) begin
                        op_write <= mem_write;
                        cnt      <= CNT_LOAD;
                        state    <= enter_resp ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        proto_err <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (enter_resp) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (op_write) begin
                        wr_count <= wr_count + 16'd1;
                    end else begin
                        rd_count <= rd_count + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The store's read register is not reset, so gate it until the first read.
    assign mem_rdata = rdata_vld ? store_rdata : '0;

    line_store #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LINE_WIDTH(LINE_WIDTH)
    ) u_store (
        .clk  (clk),
        .we   (store_we),
        .waddr(addr_q),
        .wdata(wdata_q),
        .re   (store_re),
        .raddr(store_raddr),
        .rdata(store_rdata)
    );

endmodule

// File: doc/cache_line_responder.md
Name: cache_line_responder

Overview:
- Memory-side responder for the cache's line-granular memory interface: accepts one 128-bit line read or write request at a time from the cache controller/datapath.
- Completes the request after a fixed programmable latency, then pulses mem_resp for one cycle.
- Serves as the physical-memory model and the downstream end for L1 cache simulation and FPGA bring-up.
- Backing store is internal, one entry per 12-bit line address.

Parameters:
- ADDR_WIDTH, 12, line address width; store depth is 2**ADDR_WIDTH lines.
- LINE_WIDTH, 128, bits per cache line.
- LATENCY, 4, cycles from request acceptance to mem_resp; legal range 1..255. Values outside the range are an elaboration error.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_read  input  1  line read request; held high by the initiator until mem_resp.
- mem_write  input  1  line write request; held high by the initiator until mem_resp.
- mem_address  input  ADDR_WIDTH  line address, {tag,set}.
- mem_wdata  input  LINE_WIDTH  write line.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  LINE_WIDTH  read line; valid while mem_resp=1 for a read; held afterwards.
- proto_err  output  1  sticky protocol-violation flag.
- rd_count  output  16  completed reads, wrapping.
- wr_count  output  16  completed writes, wrapping.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, mem_resp=0, mem_rdata=0, proto_err=0, rd_count=0, wr_count=0, latency counter 0. The backing store is not reset; its contents are undefined until written.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Exactly one of mem_read/mem_write high: latch address, wdata and op; load counter with LATENCY-1; go to BUSY. If LATENCY=1, go directly to RESP.
  - Both high: no acceptance, proto_err<=1, stay in IDLE.
- BUSY:
  - Decrement the counter each cycle; when it is 0, go to RESP.
  - If the latched request signal deasserts, abort: go to IDLE, no store write, no resp, proto_err<=1.
- RESP (one cycle):
  - mem_resp=1.
  - Read: mem_rdata <= store[latched addr], registered so it is valid in this cycle; rd_count++.
  - Write: store[latched addr] <= latched wdata at the end of this cycle; wr_count++; mem_rdata unchanged.
  - Next state is always IDLE.
- Latency: a request first seen high at edge N produces mem_resp high during cycle N+LATENCY.
- Back-to-back: a request still or newly high in the IDLE cycle after RESP is a new transaction. Minimum spacing between resps is LATENCY+1 cycles.
- Ordering: a read after a write to the same address returns the written line.
- Latching: mem_address and mem_wdata changes after acceptance are ignored.
- Counters wrap 0xFFFF to 0x0000.
- Reset mid-transaction: immediately go to IDLE with reset values. An in-flight write is discarded and the store is untouched.

Decomposition:
- Package cache_mem_pkg:
  - typedef line_t (LINE_WIDTH), typedef line_addr_t (ADDR_WIDTH).
  - enum resp_state_t {IDLE, BUSY, RESP}.
  - localparam MAX_LATENCY=255.
- Sub-module line_store:
  - Parameterised 2**ADDR_WIDTH x LINE_WIDTH array.
  - Synchronous write, registered read, no reset.
  - Instantiated once.
- FSM, latency counter and statistics counters stay in cache_line_responder.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no request for 10 cycles -> mem_resp=0, mem_rdata=0, counts 0, proto_err=0 throughout.
- Write then read, LATENCY=4: write addr 0x0A5, wdata 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0 at edge 10 -> mem_resp in cycle 14. Read 0x0A5 at edge 15 -> mem_resp in cycle 19 with that data; rd_count=1, wr_count=1.
- Write-back/fill pair on the same set: write 0x1F3 then read 0x0B3 -> 0x0B3 returns its own prior contents. A following read of 0x1F3 returns the written line; resp spacing is 5 cycles.
- Both requests high in IDLE -> no resp within 2*LATENCY cycles, proto_err=1 and stays 1 through later legal transactions.
- Abort: read accepted, mem_read dropped after 2 cycles -> no mem_resp, rd_count unchanged, proto_err=1. Next legal read completes in LATENCY.
- Reset mid-write: write 0x3FF pattern 128'h1, rst_n asserted in BUSY -> outputs return to reset values immediately. A later read of 0x3FF returns the old contents, not 128'h1.
